// File: rtl/alu_cmd_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_cmd_sequencer_if
// Bundles the three sides of the ALU command sequencer into one interface.
//   Command side : in_data[7:0], in_valid, in_ready
//   ALU side     : alu_in[7:0] (to ALU), alu_out[7:0] (from ALU)
//   Result side  : res_data[7:0], res_valid, res_ready, res_err
//   Status       : busy
// Modports:
//   slave  - the sequencer itself
//   master - the surrounding system (command source, ALU, result sink)
// ----------------------------------------------------------------------------
interface alu_cmd_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] alu_in;
  logic [7:0] alu_out;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_ready;
  logic       res_err;
  logic       busy;

  modport slave (
    input  in_data, in_valid, alu_out, res_ready,
    output in_ready, alu_in, res_data, res_valid, res_err, busy
  );

  modport master (
    output in_data, in_valid, alu_out, res_ready,
    input  in_ready, alu_in, res_data, res_valid, res_err, busy
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// alu_cmd_sequencer
// Queues 8-bit ALU command bytes in a small FIFO and plays them one at a time
// into an external 8-bit ALU, capturing each ALU output byte as a result that
// is held until the downstream side accepts it.
//
// Command byte: [7:6] opcode (00 add, 01 sub, 10 mul, 11 div),
//               [5:3] operand B, [2:0] operand A.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - alu_cmd_sequencer_if.slave:
//          in_data/in_valid/in_ready    command push (in_ready = not full)
//          alu_in / alu_out             external ALU drive and result
//          res_data/res_valid/res_ready result handshake
//          res_err                      result flagged erroneous
//          busy                         FIFO non-empty or sequencer active
//
// Parameter:
//   DEPTH - command FIFO entries (power of two, >= 2)
//
// Optional feature (macro ALU_SEQ_DIVZERO_GUARD_EN):
//   When defined, a popped divide with operand B == 0 never reaches the ALU;
//   it produces res_data = 0xFF with res_err = 1 directly. When undefined,
//   such commands are issued normally and res_err is constant 0.
// ----------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_cmd_sequencer_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_SAMPLE,
    S_OUT
  } state_t;

  state_t           state, state_nxt;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             empty, full;
  logic             push, pop;
  logic [7:0]       head;

  logic             load_cmd;
  logic             capture;
  logic             res_clr;
  logic             guard_hit;
  logic             guard_sel;

  logic [7:0]       alu_in_q;
  logic [7:0]       res_data_q;
  logic             res_vld;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);
  assign head  = mem[rd_ptr];
  assign push  = bus.in_valid && !full;

  assign bus.in_ready  = !full;
  assign bus.alu_in    = alu_in_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_valid = res_vld;
  assign bus.busy      = !empty || (state != S_IDLE);

`ifdef ALU_SEQ_DIVZERO_GUARD_EN
  logic res_err_q;

  function automatic logic is_div_zero(input logic [7:0] c);
    return (c[7:6] == 2'b11) && (c[5:3] == 3'b000);
  endfunction

  assign guard_sel   = is_div_zero(head);
  assign bus.res_err = res_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_err_q <= 1'b0;
    end else if (guard_hit) begin
      res_err_q <= 1'b1;
    end else if (capture || res_clr) begin
      res_err_q <= 1'b0;
    end
  end
`else
  assign guard_sel   = 1'b0;
  assign bus.res_err = 1'b0;
`endif

  // Command FIFO: pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state: a pop happens from IDLE, or from OUT on the same edge that
  // retires the current result, so back-to-back commands cost 3 cycles each.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_cmd  = 1'b0;
    capture   = 1'b0;
    res_clr   = 1'b0;
    guard_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (guard_sel) begin
            guard_hit = 1'b1;
            state_nxt = S_OUT;
          end else begin
            load_cmd  = 1'b1;
            state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        capture   = 1'b1;
        state_nxt = S_OUT;
      end
      S_OUT: begin
        if (bus.res_ready) begin
          res_clr = 1'b1;
          if (!empty) begin
            pop = 1'b1;
            if (guard_sel) begin
              guard_hit = 1'b1;
              state_nxt = S_OUT;
            end else begin
              load_cmd  = 1'b1;
              state_nxt = S_ISSUE;
            end
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Issue stage: alu_in is the command register and only moves on a pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           alu_in_q <= 8'h00;
    else if (load_cmd) alu_in_q <= head;
  end

  // Capture stage: guarded result takes priority over retiring the old one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data_q <= 8'h00;
      res_vld    <= 1'b0;
    end else if (capture) begin
      res_data_q <= bus.alu_out;
      res_vld    <= 1'b1;
    end else if (guard_hit) begin
      res_data_q <= 8'hFF;
      res_vld    <= 1'b1;
    end else if (res_clr) begin
      res_vld    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Self-checking bench for alu_cmd_sequencer. Provides a behavioural 8-bit
// ALU, directed scenarios (reset, latency, ordering, back-pressure, reset
// mid-operation, divide by zero) and a randomized phase scored against a
// queue-based reference of outstanding commands.
// Honors ALU_SEQ_DIVZERO_GUARD_EN to match the design build.
// ----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if bus();

  alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [7:0] alu_ref(input logic [7:0] c);
    int a, b, r;
    a = int'(c[2:0]);
    b = int'(c[5:3]);
    case (c[7:6])
      2'b00:   r = a + b;
      2'b01:   r = a - b;
      2'b10:   r = a * b;
      default: r = (b == 0) ? 0 : a / b;
    endcase
    return {c[7:6], 6'(r)};
  endfunction

  assign bus.alu_out = alu_ref(bus.alu_in);

  function automatic logic is_dz(input logic [7:0] c);
    return (c[7:6] == 2'b11) && (c[5:3] == 3'b000);
  endfunction

  function automatic logic [7:0] exp_res(input logic [7:0] c);
`ifdef ALU_SEQ_DIVZERO_GUARD_EN
    if (is_dz(c)) return 8'hFF;
`endif
    return alu_ref(c);
  endfunction

  function automatic logic exp_err(input logic [7:0] c);
`ifdef ALU_SEQ_DIVZERO_GUARD_EN
    return is_dz(c);
`else
    return 1'b0;
`endif
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: commands accepted but not yet handed downstream, in order
  logic [7:0] exp_q[$];
  logic       prev_vld, prev_rdy;
  logic [7:0] prev_data;

  task automatic model_cycle(input bit allow_push, input int rdy_pct);
    logic hs, psh;
    chk("busy", bus.busy, exp_q.size() != 0);
    chk("in_ready", bus.in_ready, exp_q.size() <= DEPTH);
    if (prev_vld && !prev_rdy) begin
      chk("hold_valid", bus.res_valid, 1'b1);
      chk("hold_data", bus.res_data, prev_data);
    end
    bus.in_valid  = allow_push && ($urandom_range(0, 99) < 60);
    bus.in_data   = 8'($urandom);
    bus.res_ready = ($urandom_range(0, 99) < rdy_pct);
    psh = bus.in_valid && bus.in_ready;
    hs  = bus.res_valid && bus.res_ready;
    if (hs) begin
      if (exp_q.size() == 0) begin
        chk("spurious_result", 1'b1, 1'b0);
      end else begin
        chk("rand_res_data", bus.res_data, exp_res(exp_q[0]));
        chk("rand_res_err", bus.res_err, exp_err(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
    if (psh) exp_q.push_back(bus.in_data);
    prev_vld  = bus.res_valid;
    prev_rdy  = bus.res_ready;
    prev_data = bus.res_data;
    cyc();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cmds [8];
    logic [7:0] got_d [3];
    int         got_t [3];
    int         n_got, acc, cnt;
    logic [7:0] held;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.res_ready = 1'b0;
    cyc();
    cyc();

    // Reset values while reset is held
    chk("rst_alu_in",   bus.alu_in,    8'h00);
    chk("rst_res_data", bus.res_data,  8'h00);
    chk("rst_res_vld",  bus.res_valid, 1'b0);
    chk("rst_res_err",  bus.res_err,   1'b0);
    chk("rst_busy",     bus.busy,      1'b0);
    chk("rst_in_ready", bus.in_ready,  1'b1);
    rst = 1'b0;
    cyc();

    // Single add: latency of 3 edges from push to res_valid
    bus.res_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h1A;
    cyc();
    bus.in_valid  = 1'b0;
    chk("lat_busy_k", bus.busy, 1'b1);
    chk("lat_vld_k", bus.res_valid, 1'b0);
    cyc();
    chk("lat_alu_in_k1", bus.alu_in, 8'h1A);
    chk("lat_vld_k1", bus.res_valid, 1'b0);
    cyc();
    chk("lat_alu_in_k2", bus.alu_in, 8'h1A);
    chk("lat_vld_k2", bus.res_valid, 1'b0);
    cyc();
    chk("lat_vld_k3", bus.res_valid, 1'b1);
    chk("lat_data_k3", bus.res_data, 8'h05);
    chk("lat_err_k3", bus.res_err, 1'b0);
    cyc();
    chk("lat_vld_done", bus.res_valid, 1'b0);
    chk("lat_busy_done", bus.busy, 1'b0);
    chk("lat_alu_in_idle", bus.alu_in, 8'h1A);

    // Back-to-back sub/mul/div: order and 3-cycle spacing
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h53;
    cyc();
    bus.in_data  = 8'h9B;
    cyc();
    bus.in_data  = 8'hE7;
    cyc();
    bus.in_valid = 1'b0;
    n_got = 0;
    for (int t = 0; t < 30; t++) begin
      if (bus.res_valid) begin
        if (n_got < 3) begin
          got_d[n_got] = bus.res_data;
          got_t[n_got] = t;
        end
        n_got++;
      end
      cyc();
    end
    chk("b2b_count", n_got, 3);
    if (n_got >= 3) begin
      chk("b2b_res0", got_d[0], 8'h41);
      chk("b2b_res1", got_d[1], 8'h89);
      chk("b2b_res2", got_d[2], 8'hC1);
      chk("b2b_gap01", got_t[1] - got_t[0], 3);
      chk("b2b_gap12", got_t[2] - got_t[1], 3);
    end

    // Back-pressure: DEPTH+1 accepted, extra push blocked, drain in order
    bus.res_ready = 1'b0;
    foreach (cmds[i]) cmds[i] = 8'($urandom);
    acc = 0;
    for (int c = 0; c < DEPTH + 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = cmds[acc];
      if (bus.in_ready && acc < 7) acc++;
      cyc();
    end
    bus.in_valid = 1'b0;
    chk("bp_accepted", acc, DEPTH + 1);
    chk("bp_in_ready", bus.in_ready, 1'b0);
    chk("bp_res_vld", bus.res_valid, 1'b1);
    chk("bp_res_data", bus.res_data, exp_res(cmds[0]));
    held = bus.res_data;
    cyc();
    cyc();
    chk("bp_res_stable", bus.res_data, held);
    bus.res_ready = 1'b1;
    n_got = 0;
    for (int c = 0; c < 60; c++) begin
      if (bus.res_valid) begin
        if (n_got < 8) chk("bp_drain_data", bus.res_data, exp_res(cmds[n_got]));
        n_got++;
      end
      cyc();
    end
    chk("bp_drain_count", n_got, DEPTH + 1);
    chk("bp_idle", bus.busy, 1'b0);

    // Reset during SAMPLE with two commands queued
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h1A;
    cyc();
    bus.in_data  = 8'h53;
    cyc();
    bus.in_data  = 8'h9B;
    cyc();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_alu_in",   bus.alu_in,    8'h00);
    chk("mrst_res_data", bus.res_data,  8'h00);
    chk("mrst_res_vld",  bus.res_valid, 1'b0);
    chk("mrst_res_err",  bus.res_err,   1'b0);
    chk("mrst_busy",     bus.busy,      1'b0);
    chk("mrst_in_ready", bus.in_ready,  1'b1);
    cyc();
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.res_valid) cnt++;
      cyc();
    end
    chk("mrst_no_results", cnt, 0);
    chk("mrst_busy_after", bus.busy, 1'b0);

    // Prime alu_in, then divide by zero
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h1A;
    cyc();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 6; c++) cyc();
    chk("dz_prime_alu_in", bus.alu_in, 8'h1A);
    bus.res_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hC5;
    cyc();
    bus.in_valid  = 1'b0;
    cyc();
`ifdef ALU_SEQ_DIVZERO_GUARD_EN
    chk("dz_vld", bus.res_valid, 1'b1);
    chk("dz_data", bus.res_data, 8'hFF);
    chk("dz_err", bus.res_err, 1'b1);
    chk("dz_alu_in", bus.alu_in, 8'h1A);
    bus.res_ready = 1'b1;
    cyc();
    chk("dz_err_clr", bus.res_err, 1'b0);
    chk("dz_vld_clr", bus.res_valid, 1'b0);
`else
    chk("dz_alu_in", bus.alu_in, 8'hC5);
    chk("dz_vld_k1", bus.res_valid, 1'b0);
    cyc();
    cyc();
    chk("dz_vld", bus.res_valid, 1'b1);
    chk("dz_data", bus.res_data, alu_ref(8'hC5));
    chk("dz_err", bus.res_err, 1'b0);
    bus.res_ready = 1'b1;
    cyc();
    chk("dz_vld_clr", bus.res_valid, 1'b0);
`endif

    // Randomized traffic against the queue reference
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_q.delete();
    prev_vld = 1'b0;
    prev_rdy = 1'b0;
    prev_data = 8'h00;
    for (int c = 0; c < 600; c++) model_cycle(1'b1, 70);
    for (int c = 0; c < 600; c++) model_cycle(1'b1, 25);
    for (int c = 0; c < 120; c++) model_cycle(1'b0, 100);
    chk("rand_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have parameter: DEPTH, 4, command FIFO entries; power of two, >=2.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_data  input  8  command byte; [7:6] opcode (00 add, 01 sub, 10 mul, 11 div), [5:3] operand B, [2:0] operand A.
REQ-005 SHALL have port: in_valid  input  1  upstream command offered.
REQ-006 SHALL have port: in_ready  output  1  FIFO can accept; equals not-full.
REQ-007 SHALL have port: alu_in  output  8  drives the 8-bit ALU inputs IN7..IN0.
REQ-008 SHALL have port: alu_out  input  8  ALU outputs OUT7..OUT0.
REQ-009 SHALL have port: res_data  output  8  captured result byte.
REQ-010 SHALL have port: res_valid  output  1  res_data valid.
REQ-011 SHALL have port: res_ready  input  1  downstream accepts result.
REQ-012 SHALL have port: res_err  output  1  result flagged erroneous (see Configuration).
REQ-013 SHALL have port: busy  output  1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-014 SHALL push in_data into FIFO on edge where in_valid && in_ready; no push when full.
REQ-015 SHALL allow simultaneous push and pop when not full; occupancy unchanged, order preserved; pointers wrap modulo DEPTH.
REQ-016 SHALL implement FSM states IDLE, ISSUE, SAMPLE, OUT.
REQ-017 IDLE: FIFO non-empty -> pop head into cmd register, go ISSUE; else stay.
REQ-018 ISSUE: alu_in = cmd; next edge (ALU samples) -> SAMPLE.
REQ-019 SAMPLE: alu_in held = cmd; next edge captures alu_out into res_data, sets res_valid, -> OUT.
REQ-020 OUT: hold res_data/res_valid stable until res_valid && res_ready edge; then pop next and go ISSUE if FIFO non-empty, else IDLE with res_valid cleared.
REQ-021 alu_in SHALL hold last issued command while IDLE/OUT; never change during ISSUE/SAMPLE.
REQ-022 Latency: command pushed at edge k into empty FIFO with FSM IDLE -> res_valid high after edge k+3.
REQ-023 Throughput with res_ready held high: one result per 3 cycles.
REQ-024 res_data SHALL be alu_out bit-exact (opcode on [7:6], 6-bit result on [5:0]); no arithmetic in this block.

Reset
REQ-025 rst high SHALL immediately clear: FIFO empty, FSM IDLE, alu_in=0x00, res_data=0x00, res_valid=0, res_err=0, busy=0, in_ready=1.
REQ-026 rst mid-operation SHALL discard in-flight and queued commands; no result emitted for them.

Configuration
REQ-027 Macro ALU_SEQ_DIVZERO_GUARD_EN defined: popped command with opcode 11 and operand B 000 SHALL bypass ISSUE/SAMPLE, alu_in unchanged, enter OUT on next edge with res_data=0xFF, res_err=1.
REQ-028 res_err SHALL clear on the next result handshake; non-guarded results have res_err=0.
REQ-029 Macro undefined: no guard logic; divide-by-zero issued normally; res_err tied 0.

Verification
REQ-030 Reset, push 0x1A (add A=2,B=3), res_ready=1 -> alu_in=0x1A after edge k+1, res_valid after edge k+3, res_data=0x05.
REQ-031 Push 0x53 (sub A=3,B=2), 0x9B (mul A=3,B=3), 0xE7 (div A=7,B=4) back-to-back -> results 0x41, 0x89, 0xC1 in order, spaced 3 cycles.
REQ-032 res_ready=0, push DEPTH+1 commands -> in_ready low after DEPTH+1 accepted (FIFO plus cmd reg); extra push blocked; res_data stable; drain in order.
REQ-033 Assert rst during SAMPLE with 2 queued -> all outputs at reset values same cycle; no results after release.
REQ-034 With ALU_SEQ_DIVZERO_GUARD_EN, push 0xC5 -> res_data=0xFF, res_err=1, alu_in unchanged; without macro, command issued to ALU, res_err=0.
